mem_req_arb: RTL and testbench
==============================

Name: mem_req_arb

Overview:
- Shares one downstream memory request port (toward IC/L2) between NUM_REQ requesters, e.g. the FE fill buffer and a page walker.
- Arbitrates round-robin and renames each accepted request to a downstream tag drawn from a free pool. A tag table records source and original id.
- Each downstream response is routed back to its requester with the original id restored, and the tag is freed.

Parameters:
- NUM_REQ, 2, number of upstream requesters (>=2).
- NUM_TAGS, 8, max in-flight downstream requests. Power of 2, <= 2^width(t_mem_id).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- up_req_pkt  in  NUM_REQ x t_mem_req_pkt  per-requester request; held stable while valid & ~up_req_gnt
- up_req_gnt  out  NUM_REQ  one-hot accept, same cycle
- up_rsp_pkt  out  NUM_REQ x t_mem_rsp_pkt  routed response, original id restored
- ds_req_pkt  out  t_mem_req_pkt  downstream request; id = allocated tag
- ds_req_rdy  in  1  downstream can accept this cycle
- ds_rsp_pkt  in  t_mem_rsp_pkt  downstream response; id = tag
- tags_busy  out  $clog2(NUM_TAGS)+1  count of allocated tags (perf/debug)

Behaviour:
State:
- TAGTAB[NUM_TAGS], each entry {valid, src (lg2 NUM_REQ), orig_id}.
- rr_ptr (lg2 NUM_REQ).
- busy_cnt.

Reset:
- TAGTAB valid = 0, rr_ptr = 0, busy_cnt = 0.
- While reset is asserted: up_req_gnt = 0, ds_req_pkt.valid = 0, up_rsp_pkt[*].valid = 0.
- Reset mid-flight drops all outstanding tags. Any late downstream response is dropped (see stale-tag rule).

Allocation:
- free_tag = lowest-index invalid TAGTAB entry.
- tag_avail = any entry invalid, evaluated on registered state.

Arbitration (combinational, 0-cycle):
- sel = first requester with up_req_pkt.valid, searching from rr_ptr upward with wrap.
- ds_req_pkt.valid = any up valid & tag_avail.
- ds_req_pkt = up_req_pkt[sel] with id replaced by free_tag (zero-extended).
- up_req_gnt[sel] = ds_req_pkt.valid & ds_req_rdy. All other gnt bits are 0.
- ds_req_pkt is driven even when ds_req_rdy = 0. It may change source next cycle only if a higher-priority requester arrives; rr_ptr holds until an accept.

On accept (gnt):
- TAGTAB[free_tag] <= {1, sel, orig id}.
- rr_ptr <= sel+1 mod NUM_REQ.

Response (combinational route, 0-cycle):
- If ds_rsp_pkt.valid & TAGTAB[id].valid: up_rsp_pkt[src] = ds_rsp_pkt with id = orig_id. Other requesters see valid = 0.
- TAGTAB[id].valid <= 0 at the clock edge.
- A freed tag is allocatable from the next cycle, never in the same cycle.

Stale tag (TAGTAB[id].valid = 0 or id >= NUM_TAGS):
- Response dropped, no output, table unchanged.
- Assertion fires under ASSERT.

Simultaneous accept and response:
- Both take effect.
- busy_cnt <= busy_cnt + accept - free, so the count is unchanged when both occur.
- The accepted tag and the freed tag are always distinct.

Full:
- When busy_cnt == NUM_TAGS: ds_req_pkt.valid = 0 and no grants.
- A response in that cycle frees a tag for the next cycle.

Width:
- Tag field is zero-extended into t_mem_id.
- orig_id is stored at full t_mem_id width.

Invariant:
- tags_busy == popcount(TAGTAB.valid). Assert each cycle.

Decomposition:
- mem_common package:
  - MEM_ARB_NUM_TAGS and MEM_ARB_TAG_BITS.
  - Typedef t_arb_tag_ent {valid, src, orig_id}.
- Reuse the gen_funcs find_first1/find_first0 and oh_encode helpers, plus a rotate-left helper for the round-robin search.
- One natural sub-module, rr_arb: parameterised round-robin picker with inputs {rq vector, advance} and outputs {gnt one-hot, encoded sel}.
- The tag table stays inline.

Test Plan:
- Single requester, NUM_TAGS=8, ds_req_rdy=1: req0 sends ids 5,6,7 on consecutive cycles → ds ids 0,1,2, gnt0 each cycle. Responses with tags 2,0,1 → up_rsp[0] ids 7,5,6.
- Both requesters valid every cycle, rdy=1 → grants alternate 0,1,0,1 starting with req0 after reset. Responses return to the correct source with orig ids.
- Fill: 8 accepts with no responses → 9th cycle ds valid=0, no gnt, tags_busy=8. Response tag 3 → next cycle the request is accepted with tag 3.
- ds_req_rdy=0 for 3 cycles with req1 valid → ds_req_pkt held, gnt=0, rr_ptr unchanged. rdy=1 → gnt1, tag 0.
- Same cycle: accept into tag 4 and response for tag 0 → both applied, tags_busy unchanged. Tag 0 is not reused in that cycle.
- Reset asserted with 5 tags busy, then a response with tag 2 after release → dropped, no up_rsp valid, assertion flagged. Next request gets tag 0.

Source files
------------

// File: rtl/mem_req_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_arb_pkg
//   Shared memory-request types, arbiter tag-table constants and small
//   bit-vector helpers used by the memory request arbiter.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package mem_req_arb_pkg;

  localparam int MEM_ID_W         = 4;
  localparam int MEM_ADDR_W       = 32;
  localparam int MEM_DATA_W       = 32;
  localparam int MEM_ARB_NUM_TAGS = 8;
  localparam int MEM_ARB_TAG_BITS = $clog2(MEM_ARB_NUM_TAGS);
  // Wide enough for any practical requester count; stored zero-extended.
  localparam int MEM_ARB_SRC_BITS = 4;

  typedef logic [MEM_ID_W-1:0] t_mem_id;

  typedef struct packed {
    logic                  valid;
    t_mem_id               id;
    logic [MEM_ADDR_W-1:0] addr;
  } t_mem_req_pkt;

  typedef struct packed {
    logic                  valid;
    t_mem_id               id;
    logic [MEM_DATA_W-1:0] data;
  } t_mem_rsp_pkt;

  typedef struct packed {
    logic                        valid;
    logic [MEM_ARB_SRC_BITS-1:0] src;
    t_mem_id                     orig_id;
  } t_arb_tag_ent;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int find_first1(input logic [31:0] v);
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!found && v[i]) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Index of the lowest clear bit.
  function automatic int find_first0(input logic [31:0] v);
    return find_first1(~v);
  endfunction

  // Binary index of a one-hot vector.
  function automatic int oh_encode(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Rotate the low n bits of v left by amt (0 <= amt <= n); upper bits cleared.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int amt, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) r[5'((i + amt) % n)] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_req_arb_rr_arb.sv
// -----------------------------------------------------------------------------
// mem_req_arb_rr_arb
//   Round-robin picker. Searches rq from the priority pointer upward with
//   wrap; the pointer moves past the winner only when advance is high.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     rq         : request vector
//     advance    : winner accepted this cycle, rotate priority
//     gnt        : one-hot winner (zero when rq is empty)
//     sel        : encoded winner
// -----------------------------------------------------------------------------
module mem_req_arb_rr_arb
  import mem_req_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  rq,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] sel
);

  logic [SW-1:0] rr_ptr;
  logic [31:0]   rq_rot;
  logic [31:0]   oh_rot;

  // Rotate so the pointer position becomes bit 0, take the first request,
  // then rotate the one-hot winner back into requester numbering.
  always_comb begin
    rq_rot = rotl(32'(rq), N - int'(rr_ptr), N);
    oh_rot = 32'(1) << find_first1(rq_rot);
    gnt    = (|rq) ? N'(rotl(oh_rot, int'(rr_ptr), N)) : '0;
    sel    = SW'(oh_encode(32'(gnt)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (sel == SW'(N - 1)) ? '0 : sel + SW'(1);
    end
  end

endmodule

// File: rtl/mem_req_arb.sv
// -----------------------------------------------------------------------------
// mem_req_arb
//   Shares one downstream memory request port between NUM_REQ requesters.
//   Accepted requests are renamed to a free downstream tag; the tag table
//   remembers source and original id so responses can be routed back with
//   the original id restored.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     up_req_pkt  : per-requester request (held while valid and not granted)
//     up_req_gnt  : one-hot same-cycle accept
//     up_rsp_pkt  : per-requester routed response
//     ds_req_pkt  : downstream request, id = allocated tag
//     ds_req_rdy  : downstream accepts this cycle
//     ds_rsp_pkt  : downstream response, id = tag
//     tags_busy   : number of allocated tags
// -----------------------------------------------------------------------------
module mem_req_arb
  import mem_req_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_TAGS = 1 << MEM_ARB_TAG_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  t_mem_req_pkt            up_req_pkt [NUM_REQ],
  output logic [NUM_REQ-1:0]      up_req_gnt,
  output t_mem_rsp_pkt            up_rsp_pkt [NUM_REQ],
  output t_mem_req_pkt            ds_req_pkt,
  input  logic                    ds_req_rdy,
  input  t_mem_rsp_pkt            ds_rsp_pkt,
  output logic [$clog2(NUM_TAGS):0] tags_busy
);

  localparam int SW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAG_BITS = $clog2(NUM_TAGS);
  localparam int CW       = TAG_BITS + 1;

  t_arb_tag_ent        tab [NUM_TAGS];
  logic [NUM_TAGS-1:0] tab_vld;
  logic [CW-1:0]       busy_cnt;
  logic [NUM_REQ-1:0]  rq_vld;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [SW-1:0]       sel;
  logic [TAG_BITS-1:0] free_tag;
  logic [TAG_BITS-1:0] rsp_tag;
  logic                tag_avail;
  logic                accept;
  logic                rsp_hit;
  t_arb_tag_ent        rsp_ent;

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) rq_vld[r] = up_req_pkt[r].valid;
    for (int t = 0; t < NUM_TAGS; t++) tab_vld[t] = tab[t].valid;
  end

  // Allocation looks only at registered state, so a tag freed this cycle
  // cannot be handed out until the next one.
  assign free_tag  = TAG_BITS'(find_first0(32'(tab_vld)));
  assign tag_avail = ~&tab_vld;

  mem_req_arb_rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .rq      (rq_vld),
    .advance (accept),
    .gnt     (arb_gnt),
    .sel     (sel)
  );

  always_comb begin
    ds_req_pkt       = up_req_pkt[sel];
    ds_req_pkt.id    = t_mem_id'(free_tag);
    ds_req_pkt.valid = ~reset & tag_avail & (|rq_vld);
  end

  assign accept     = ds_req_pkt.valid & ds_req_rdy;
  assign up_req_gnt = accept ? arb_gnt : '0;

  // Responses whose tag is out of range or not allocated are dropped.
  assign rsp_tag = ds_rsp_pkt.id[TAG_BITS-1:0];
  assign rsp_ent = tab[rsp_tag];
  assign rsp_hit = ~reset & ds_rsp_pkt.valid & (int'(ds_rsp_pkt.id) < NUM_TAGS) & rsp_ent.valid;

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      up_rsp_pkt[r]       = ds_rsp_pkt;
      up_rsp_pkt[r].id    = rsp_ent.orig_id;
      up_rsp_pkt[r].valid = rsp_hit & (rsp_ent.src == MEM_ARB_SRC_BITS'(r));
    end
  end

  // The accepted tag is always free and the released tag always allocated,
  // so both updates can land in the same cycle without colliding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NUM_TAGS; t++) tab[t].valid <= 1'b0;
      busy_cnt <= '0;
    end else begin
      if (accept) begin
        tab[free_tag] <= '{valid:   1'b1,
                           src:     MEM_ARB_SRC_BITS'(sel),
                           orig_id: up_req_pkt[sel].id};
      end
      if (rsp_hit) tab[rsp_tag].valid <= 1'b0;
      busy_cnt <= busy_cnt + CW'(accept) - CW'(rsp_hit);
    end
  end

  assign tags_busy = busy_cnt;

`ifdef ASSERT
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(ds_rsp_pkt.valid && !rsp_hit))
        else $error("mem_req_arb: response with stale tag %0d", ds_rsp_pkt.id);
      assert ($countones(tab_vld) == int'(busy_cnt))
        else $error("mem_req_arb: busy count %0d disagrees with table", busy_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arb
//   Directed vector table for the arbiter corner cases followed by a random
//   traffic phase checked against a reference model with a response queue.
// -----------------------------------------------------------------------------
module tb_mem_req_arb;
  import mem_req_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  t_mem_req_pkt up_req_pkt [2];
  logic [1:0]   up_req_gnt;
  t_mem_rsp_pkt up_rsp_pkt [2];
  t_mem_req_pkt ds_req_pkt;
  logic         ds_req_rdy;
  t_mem_rsp_pkt ds_rsp_pkt;
  logic [3:0]   tags_busy;

  mem_req_arb #(.NUM_REQ(2), .NUM_TAGS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .up_req_pkt (up_req_pkt),
    .up_req_gnt (up_req_gnt),
    .up_rsp_pkt (up_rsp_pkt),
    .ds_req_pkt (ds_req_pkt),
    .ds_req_rdy (ds_req_rdy),
    .ds_rsp_pkt (ds_rsp_pkt),
    .tags_busy  (tags_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int src, input t_mem_id id);
    return (src != 0 ? 32'h2000_0000 : 32'h1000_0000) | 32'(id);
  endfunction

  task automatic drive(input logic rst, input logic [1:0] v, input t_mem_id id0,
                       input t_mem_id id1, input logic rdy, input logic rv, input t_mem_id rid);
    reset         = rst;
    up_req_pkt[0] = '{valid: v[0], id: id0, addr: addr_of(0, id0)};
    up_req_pkt[1] = '{valid: v[1], id: id1, addr: addr_of(1, id1)};
    ds_req_rdy    = rdy;
    ds_rsp_pkt    = '{valid: rv, id: rid, data: 32'hD000_0000 | 32'(rid)};
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] v;
    t_mem_id    id0, id1;
    logic       rdy, rv;
    t_mem_id    rid;
    logic [1:0] e_gnt;
    logic       e_dsv;
    t_mem_id    e_dsid;
    int         e_src;
    logic [1:0] e_rspv;
    t_mem_id    e_rspid;
    logic [3:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [1:0] v, input int id0, input int id1,
                              input logic rdy, input logic rv, input int rid,
                              input logic [1:0] e_gnt, input logic e_dsv, input int e_dsid,
                              input int e_src, input logic [1:0] e_rspv, input int e_rspid,
                              input int e_busy);
    vec_t x;
    x.rst = rst;  x.v = v;  x.id0 = t_mem_id'(id0);  x.id1 = t_mem_id'(id1);
    x.rdy = rdy;  x.rv = rv;  x.rid = t_mem_id'(rid);
    x.e_gnt = e_gnt;  x.e_dsv = e_dsv;  x.e_dsid = t_mem_id'(e_dsid);  x.e_src = e_src;
    x.e_rspv = e_rspv;  x.e_rspid = t_mem_id'(e_rspid);  x.e_busy = 4'(e_busy);
    vecs.push_back(x);
  endfunction

  typedef struct {
    int      src;
    t_mem_id oid;
  } exp_rsp_t;

  exp_rsp_t sbq[$];

  initial begin
    logic       mv   [8];
    int         msrc [8];
    t_mem_id    moid [8];
    int         mptr, mbusy;
    logic       pv   [2];
    logic       pend [2];
    t_mem_id    pid  [2];

    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;

    // reset state with live inputs: everything gated
    add(1, 2'b11, 5, 5, 1, 1, 0,  2'b00, 0, 0, 0,  2'b00, 0, 0);
    // single requester, consecutive ids, out-of-order responses
    add(0, 2'b01, 5, 0, 1, 0, 0,  2'b01, 1, 0, 0,  2'b00, 0, 0);
    add(0, 2'b01, 6, 0, 1, 0, 0,  2'b01, 1, 1, 0,  2'b00, 0, 1);
    add(0, 2'b01, 7, 0, 1, 0, 0,  2'b01, 1, 2, 0,  2'b00, 0, 2);
    add(0, 2'b00, 0, 0, 1, 1, 2,  2'b00, 0, 0, 0,  2'b01, 7, 3);
    add(0, 2'b00, 0, 0, 1, 1, 0,  2'b00, 0, 0, 0,  2'b01, 5, 2);
    add(0, 2'b00, 0, 0, 1, 1, 1,  2'b00, 0, 0, 0,  2'b01, 6, 1);
    // both requesters: alternation from req0 after reset
    add(1, 2'b00, 0, 0, 1, 0, 0,  2'b00, 0, 0, 0,  2'b00, 0, 0);
    add(0, 2'b11, 1, 2, 1, 0, 0,  2'b01, 1, 0, 0,  2'b00, 0, 0);
    add(0, 2'b11, 3, 2, 1, 0, 0,  2'b10, 1, 1, 1,  2'b00, 0, 1);
    add(0, 2'b11, 3, 4, 1, 0, 0,  2'b01, 1, 2, 0,  2'b00, 0, 2);
    add(0, 2'b11, 9, 4, 1, 0, 0,  2'b10, 1, 3, 1,  2'b00, 0, 3);
    add(0, 2'b00, 0, 0, 1, 1, 3,  2'b00, 0, 0, 0,  2'b10, 4, 4);
    add(0, 2'b00, 0, 0, 1, 1, 0,  2'b00, 0, 0, 0,  2'b01, 1, 3);
    add(0, 2'b00, 0, 0, 1, 1, 1,  2'b00, 0, 0, 0,  2'b10, 2, 2);
    add(0, 2'b00, 0, 0, 1, 1, 2,  2'b00, 0, 0, 0,  2'b01, 3, 1);
    // fill all tags, then full behaviour and same-cycle free
    for (int k = 0; k < 8; k++)
      add(0, 2'b01, k, 0, 1, 0, 0,  2'b01, 1, k, 0,  2'b00, 0, k);
    add(0, 2'b01, 8, 0, 1, 0, 0,  2'b00, 0, 0, 0,  2'b00, 0, 8);
    add(0, 2'b01, 8, 0, 1, 1, 3,  2'b00, 0, 0, 0,  2'b01, 3, 8);
    add(0, 2'b01, 8, 0, 1, 0, 0,  2'b01, 1, 3, 0,  2'b00, 0, 7);
    for (int k = 0; k < 8; k++)
      add(0, 2'b00, 0, 0, 1, 1, k,  2'b00, 0, 0, 0,  2'b01, (k == 3) ? 8 : k, 8 - k);
    // downstream stall: request held, pointer keeps req1 first
    for (int k = 0; k < 3; k++)
      add(0, 2'b10, 0, 6, 0, 0, 0,  2'b00, 1, 0, 1,  2'b00, 0, 0);
    add(0, 2'b11, 2, 6, 1, 0, 0,  2'b10, 1, 0, 1,  2'b00, 0, 0);
    add(0, 2'b01, 2, 0, 1, 0, 0,  2'b01, 1, 1, 0,  2'b00, 0, 1);
    // accept into tag 4 while tag 0 returns; tag 0 reusable next cycle
    add(0, 2'b01, 10, 0, 1, 0, 0, 2'b01, 1, 2, 0,  2'b00, 0, 2);
    add(0, 2'b01, 11, 0, 1, 0, 0, 2'b01, 1, 3, 0,  2'b00, 0, 3);
    add(0, 2'b01, 12, 0, 1, 1, 0, 2'b01, 1, 4, 0,  2'b10, 6, 4);
    add(0, 2'b01, 13, 0, 1, 0, 0, 2'b01, 1, 0, 0,  2'b00, 0, 4);
    // reset with 5 tags busy; late responses dropped afterwards
    add(0, 2'b00, 0, 0, 1, 0, 0,  2'b00, 0, 0, 0,  2'b00, 0, 5);
    add(1, 2'b01, 3, 0, 1, 1, 2,  2'b00, 0, 0, 0,  2'b00, 0, 0);
    add(0, 2'b00, 0, 0, 1, 1, 2,  2'b00, 0, 0, 0,  2'b00, 0, 0);
    add(0, 2'b00, 0, 0, 1, 1, 9,  2'b00, 0, 0, 0,  2'b00, 0, 0);
    add(0, 2'b01, 3, 0, 1, 0, 0,  2'b01, 1, 0, 0,  2'b00, 0, 0);
    add(0, 2'b00, 0, 0, 1, 1, 0,  2'b00, 0, 0, 0,  2'b01, 3, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t x;
      x = vecs[i];
      drive(x.rst, x.v, x.id0, x.id1, x.rdy, x.rv, x.rid);
      @(negedge clk);
      check($sformatf("v%0d.gnt", i), 32'(up_req_gnt), 32'(x.e_gnt));
      check($sformatf("v%0d.ds_valid", i), 32'(ds_req_pkt.valid), 32'(x.e_dsv));
      if (x.e_dsv) begin
        check($sformatf("v%0d.ds_id", i), 32'(ds_req_pkt.id), 32'(x.e_dsid));
        check($sformatf("v%0d.ds_addr", i), ds_req_pkt.addr,
              addr_of(x.e_src, (x.e_src != 0) ? x.id1 : x.id0));
      end
      check($sformatf("v%0d.rsp_valid", i), 32'({up_rsp_pkt[1].valid, up_rsp_pkt[0].valid}),
            32'(x.e_rspv));
      if (x.e_rspv != 2'b00) begin
        check($sformatf("v%0d.rsp_id", i), 32'(up_rsp_pkt[int'(x.e_rspv[1])].id), 32'(x.e_rspid));
        check($sformatf("v%0d.rsp_data", i), up_rsp_pkt[int'(x.e_rspv[1])].data,
              32'hD000_0000 | 32'(x.rid));
      end
      check($sformatf("v%0d.busy", i), 32'(tags_busy), 32'(x.e_busy));
      @(posedge clk); #1;
    end

    // random traffic against a reference model
    drive(1'b1, 2'b00, '0, '0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    for (int t = 0; t < 8; t++) mv[t] = 1'b0;
    mptr  = 0;
    mbusy = 0;
    pend[0] = 1'b0;  pend[1] = 1'b0;
    pv[0]   = 1'b0;  pv[1]   = 1'b0;
    pid[0]  = '0;    pid[1]  = '0;

    for (int cyc = 0; cyc < 300; cyc++) begin
      logic       rdy, rv, avail, edsv, hit;
      t_mem_id    rid;
      int         s, ftag, pick;
      logic [1:0] egnt, exp_v;
      exp_rsp_t   e;

      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          pv[r]  = ($urandom_range(0, 2) != 0);
          pid[r] = t_mem_id'($urandom_range(0, 15));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      rv  = 1'b0;
      rid = '0;
      if ($urandom_range(0, 1) == 1) begin
        rv   = 1'b1;
        pick = $urandom_range(0, 8);
        rid  = (pick == 8) ? t_mem_id'($urandom_range(8, 15)) : t_mem_id'(pick);
      end

      s = pv[mptr] ? mptr : 1 - mptr;
      avail = 1'b0;
      ftag  = 0;
      for (int t = 7; t >= 0; t--) begin
        if (!mv[t]) begin
          avail = 1'b1;
          ftag  = t;
        end
      end
      edsv = (pv[0] | pv[1]) & avail;
      egnt = (edsv & rdy) ? (2'b01 << s) : 2'b00;
      hit  = rv && (int'(rid) < 8) && mv[int'(rid[2:0])];
      if (hit) sbq.push_back('{src: msrc[int'(rid[2:0])], oid: moid[int'(rid[2:0])]});

      drive(1'b0, {pv[1], pv[0]}, pid[0], pid[1], rdy, rv, rid);
      @(negedge clk);
      check($sformatf("r%0d.gnt", cyc), 32'(up_req_gnt), 32'(egnt));
      check($sformatf("r%0d.ds_valid", cyc), 32'(ds_req_pkt.valid), 32'(edsv));
      if (edsv) begin
        check($sformatf("r%0d.ds_id", cyc), 32'(ds_req_pkt.id), 32'(ftag));
        check($sformatf("r%0d.ds_addr", cyc), ds_req_pkt.addr, addr_of(s, pid[s]));
      end
      exp_v = 2'b00;
      if (sbq.size() > 0) exp_v = 2'b01 << sbq[0].src;
      check($sformatf("r%0d.rsp_valid", cyc), 32'({up_rsp_pkt[1].valid, up_rsp_pkt[0].valid}),
            32'(exp_v));
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check($sformatf("r%0d.rsp_id", cyc), 32'(up_rsp_pkt[e.src].id), 32'(e.oid));
      end
      check($sformatf("r%0d.busy", cyc), 32'(tags_busy), 32'(mbusy));

      if (egnt != 2'b00) begin
        mv[ftag]   = 1'b1;
        msrc[ftag] = s;
        moid[ftag] = pid[s];
        mptr       = (s + 1) % 2;
        mbusy++;
      end
      if (hit) begin
        mv[int'(rid[2:0])] = 1'b0;
        mbusy--;
      end
      for (int r = 0; r < 2; r++) pend[r] = pv[r] & ~egnt[r];
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
